// File: rtl/norm_pkg.sv
// Shared types and constants for the softmax row normalization controller.
package norm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_NORM = 3'd1,
    STREAM    = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } norm_state_t;

  // Substitute factor when the denominator is zero; elements then pass unscaled.
  localparam real NORM_ZERO_SUBST = 1.0;

  // Width of a counter that must represent 0..max_len inclusive.
  function automatic int unsigned row_len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/norm_row_ctrl_if.sv
// Row control, factor, element, pipeline and output signals of norm_row_ctrl.
interface norm_row_ctrl_if import norm_pkg::*; #(
  parameter int unsigned MAX_ROW_LEN = 64
) ();

  localparam int unsigned LEN_W = row_len_width(MAX_ROW_LEN);

  logic             start;
  logic [LEN_W-1:0] row_len;
  logic             norm_valid;
  real              norm_data;
  logic             norm_ready;
  logic             x_valid;
  real              x_data;
  logic             x_ready;
  logic             pe_do_process;
  real              pe_x_in;
  real              pe_norm_in;
  real              pe_x_out;
  logic             out_valid;
  real              out_data;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err_zero_norm;

  // Producer/pipeline/consumer side.
  modport master (
    output start, row_len, norm_valid, norm_data, x_valid, x_data, pe_x_out, out_ready,
    input  norm_ready, x_ready, pe_do_process, pe_x_in, pe_norm_in,
           out_valid, out_data, out_last, busy, done, err_zero_norm
  );

  // Controller side.
  modport slave (
    input  start, row_len, norm_valid, norm_data, x_valid, x_data, pe_x_out, out_ready,
    output norm_ready, x_ready, pe_do_process, pe_x_in, pe_norm_in,
           out_valid, out_data, out_last, busy, done, err_zero_norm
  );

endinterface

// File: rtl/norm_vld_pipe.sv
// Enable-gated valid/last shift register tracking elements inside the pe pipeline.
module norm_vld_pipe #(
  parameter int unsigned PIPE_DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  input  logic vld_in,
  input  logic last_in,
  output logic vld_tail,
  output logic last_tail
);

  logic [PIPE_DEPTH-1:0] vld_q;
  logic [PIPE_DEPTH-1:0] last_q;

  if (PIPE_DEPTH > 1) begin : g_multi
    // Shift toward the tail whenever the pipeline advances.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q  <= '0;
        last_q <= '0;
      end else if (advance) begin
        vld_q  <= {vld_q[PIPE_DEPTH-2:0], vld_in};
        last_q <= {last_q[PIPE_DEPTH-2:0], last_in};
      end
    end
  end else begin : g_single
    // Single stage: load directly whenever the pipeline advances.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q  <= '0;
        last_q <= '0;
      end else if (advance) begin
        vld_q  <= vld_in;
        last_q <= last_in;
      end
    end
  end

  assign vld_tail  = vld_q[PIPE_DEPTH-1];
  assign last_tail = last_q[PIPE_DEPTH-1];

endmodule

// File: rtl/norm_row_ctrl.sv
// Sequences one softmax row through the normalization pipeline.
module norm_row_ctrl import norm_pkg::*; #(
  parameter int unsigned MAX_ROW_LEN = 64,
  parameter int unsigned PIPE_DEPTH  = 1
) (
  input logic            clk,
  input logic            reset,
  norm_row_ctrl_if.slave bus
);

  localparam int unsigned LEN_W = row_len_width(MAX_ROW_LEN);

  norm_state_t      state_q, state_d;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] row_len_q;
  real              norm_q;
  logic             err_q;
  logic             advance;
  logic             x_fire;
  logic             is_final;
  logic             start_acc;
  logic             tail_vld;
  logic             tail_last;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign is_final  = (count_q == row_len_q - LEN_W'(1));
  assign advance   = !tail_vld || bus.out_ready;
  assign x_fire    = bus.x_valid && (state_q == STREAM) && advance;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d           = state_q;
    bus.norm_ready    = 1'b0;
    bus.x_ready       = 1'b0;
    bus.pe_do_process = 1'b0;
    bus.done          = 1'b0;
    bus.busy          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.row_len == '0) ? DONE : LOAD_NORM;
      end
      LOAD_NORM: begin
        bus.norm_ready = 1'b1;
        if (bus.norm_valid) state_d = STREAM;
      end
      STREAM: begin
        bus.pe_do_process = advance;
        bus.x_ready       = advance;
        if (x_fire && is_final) state_d = DRAIN;
      end
      DRAIN: begin
        bus.pe_do_process = advance;
        if (tail_vld && bus.out_ready && tail_last) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row length, element counter, latched factor and sticky zero-factor flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      row_len_q <= '0;
      norm_q    <= 0.0;
      err_q     <= 1'b0;
    end else begin
      if (start_acc) begin
        count_q   <= '0;
        row_len_q <= bus.row_len;
        err_q     <= 1'b0;
      end else if (x_fire) begin
        count_q <= count_q + LEN_W'(1);
      end
      if ((state_q == LOAD_NORM) && bus.norm_valid) begin
        if (bus.norm_data == 0.0) begin
          norm_q <= NORM_ZERO_SUBST;
          err_q  <= 1'b1;
        end else begin
          norm_q <= bus.norm_data;
        end
      end
    end
  end

  norm_vld_pipe #(.PIPE_DEPTH(PIPE_DEPTH)) u_vld_pipe (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .vld_in    (x_fire),
    .last_in   (x_fire && is_final),
    .vld_tail  (tail_vld),
    .last_tail (tail_last)
  );

  assign bus.pe_x_in       = bus.x_data;
  assign bus.pe_norm_in    = norm_q;
  assign bus.out_valid     = tail_vld;
  assign bus.out_data      = bus.pe_x_out;
  assign bus.out_last      = tail_last;
  assign bus.err_zero_norm = err_q;

endmodule

// File: tb/tb_norm_row_ctrl.sv
// Directed bench for norm_row_ctrl at PIPE_DEPTH 1 and 3 with behavioural pe pipelines.
module tb_norm_row_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  norm_row_ctrl_if #(.MAX_ROW_LEN(64)) a_if ();
  norm_row_ctrl_if #(.MAX_ROW_LEN(64)) b_if ();

  norm_row_ctrl #(.MAX_ROW_LEN(64), .PIPE_DEPTH(1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  norm_row_ctrl #(.MAX_ROW_LEN(64), .PIPE_DEPTH(3)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

  // Behavioural pe_norm pipelines: divide at the head, then plain delay stages.
  real pa_q = 0.0;
  real pb_q [3];
  always @(posedge clk) if (a_if.pe_do_process) pa_q <= a_if.pe_x_in / a_if.pe_norm_in;
  always @(posedge clk) begin
    if (b_if.pe_do_process) begin
      pb_q[0] <= b_if.pe_x_in / b_if.pe_norm_in;
      pb_q[1] <= pb_q[0];
      pb_q[2] <= pb_q[1];
    end
  end
  always_comb a_if.pe_x_out = pa_q;
  always_comb b_if.pe_x_out = pb_q[2];

  // Observations captured by run_row_a.
  real  stim_x [64];
  real  got_d  [64];
  logic got_l  [64];
  int   acc_c  [64];
  int   out_c  [64];
  int   n_got, n_acc;
  bit   timed_out, done_now, done_after, busy_after;
  bit   st_xr, st_pe, st_hold, norm_rdy_seen;
  real  pe_norm_seen;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one row into DUT A; optional input bubbles and one output stall.
  task automatic run_row_a(input int n, input real nv, input bit bubbles, input int stall_n);
    bit  stall_started, last_seen;
    int  stalls_left;
    real stall_val;
    n_got = 0; n_acc = 0; st_xr = 0; st_pe = 0; st_hold = 1;
    stall_started = 0; last_seen = 0; stalls_left = 0; stall_val = 0.0;
    a_if.start = 1'b1; a_if.row_len = 7'(n);
    step();
    a_if.start = 1'b0;
    a_if.norm_valid = 1'b1; a_if.norm_data = nv;
    #2;
    norm_rdy_seen = a_if.norm_ready;
    step();
    a_if.norm_valid = 1'b0;
    pe_norm_seen = a_if.pe_norm_in;
    for (int c = 0; c < 400 && !last_seen; c++) begin
      a_if.x_valid = (n_acc < n) && (!bubbles || (c % 2 == 0));
      a_if.x_data  = (n_acc < 64) ? stim_x[n_acc] : 0.0;
      if (!stall_started && stall_n > 0 && a_if.out_valid) begin
        stall_started = 1; stalls_left = stall_n; stall_val = a_if.out_data;
      end
      a_if.out_ready = (stalls_left == 0);
      #2;
      if (stalls_left > 0) begin
        if (a_if.x_ready) st_xr = 1;
        if (a_if.pe_do_process) st_pe = 1;
        if (!a_if.out_valid || a_if.out_data != stall_val) st_hold = 0;
        stalls_left--;
      end
      if (a_if.x_valid && a_if.x_ready) begin
        acc_c[n_acc] = cyc; n_acc++;
      end
      if (a_if.out_valid && a_if.out_ready && n_got < 64) begin
        got_d[n_got] = a_if.out_data; got_l[n_got] = a_if.out_last;
        out_c[n_got] = cyc; n_got++;
        last_seen = a_if.out_last;
      end
      step();
    end
    a_if.x_valid = 1'b0;
    a_if.out_ready = 1'b1;
    timed_out = !last_seen;
    #2;
    done_now = a_if.done;
    step();
    #2;
    done_after = a_if.done;
    busy_after = a_if.busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    #2;
    checks++;
    if ({a_if.norm_ready, a_if.x_ready, a_if.pe_do_process, a_if.out_valid, a_if.out_last,
         a_if.busy, a_if.done, a_if.err_zero_norm} !== 8'b0) begin
      failures++; $display("FAIL reset_a_ctrl got=%b exp=00000000",
        {a_if.norm_ready, a_if.x_ready, a_if.pe_do_process, a_if.out_valid, a_if.out_last,
         a_if.busy, a_if.done, a_if.err_zero_norm});
    end
    checks++;
    if (a_if.pe_norm_in != 0.0) begin
      failures++; $display("FAIL reset_a_norm got=%f exp=0.0", a_if.pe_norm_in);
    end
    checks++;
    if ({b_if.norm_ready, b_if.x_ready, b_if.pe_do_process, b_if.out_valid, b_if.busy,
         b_if.done} !== 6'b0) begin
      failures++; $display("FAIL reset_b_ctrl got=%b exp=000000",
        {b_if.norm_ready, b_if.x_ready, b_if.pe_do_process, b_if.out_valid, b_if.busy, b_if.done});
    end
    reset = 1'b0;
    step();
    #2;
    checks++;
    if (a_if.busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle_busy got=%b exp=0", a_if.busy);
    end
  endtask

  task automatic test_basic();
    real exp_v [4] = '{1.0, 2.0, 3.0, 4.0};
    stim_x[0] = 2.0; stim_x[1] = 4.0; stim_x[2] = 6.0; stim_x[3] = 8.0;
    run_row_a(4, 2.0, 0, 0);
    checks++;
    if (timed_out || n_got != 4) begin
      failures++; $display("FAIL basic_count got=%0d exp=4 timeout=%0d", n_got, timed_out);
    end
    checks++;
    if (norm_rdy_seen !== 1'b1 || pe_norm_seen != 2.0) begin
      failures++; $display("FAIL basic_norm ready=%b norm=%f exp ready=1 norm=2.0", norm_rdy_seen, pe_norm_seen);
    end
    for (int k = 0; k < 4 && k < n_got; k++) begin
      checks++;
      if (got_d[k] != exp_v[k] || got_l[k] !== (k == 3)) begin
        failures++; $display("FAIL basic_out[%0d] got=%f last=%b exp=%f last=%b", k, got_d[k], got_l[k], exp_v[k], k == 3);
      end
      checks++;
      if (out_c[k] != acc_c[k] + 1 || out_c[k] != out_c[0] + k) begin
        failures++; $display("FAIL basic_lat[%0d] out_cyc=%0d acc_cyc=%0d first=%0d", k, out_c[k], acc_c[k], out_c[0]);
      end
    end
    checks++;
    if (done_now !== 1'b1 || done_after !== 1'b0 || busy_after !== 1'b0) begin
      failures++; $display("FAIL basic_done got=%b%b busy=%b exp=10 busy=0", done_now, done_after, busy_after);
    end
  endtask

  task automatic test_backpressure();
    real exp_v [3] = '{1.0, 2.0, 3.0};
    stim_x[0] = 4.0; stim_x[1] = 8.0; stim_x[2] = 12.0;
    run_row_a(3, 4.0, 0, 3);
    checks++;
    if (timed_out || n_got != 3) begin
      failures++; $display("FAIL bp_count got=%0d exp=3 timeout=%0d", n_got, timed_out);
    end
    checks++;
    if (st_xr || st_pe || !st_hold) begin
      failures++; $display("FAIL bp_stall x_ready=%b pe_do=%b hold=%b exp 0 0 1", st_xr, st_pe, st_hold);
    end
    for (int k = 0; k < 3 && k < n_got; k++) begin
      checks++;
      if (got_d[k] != exp_v[k]) begin
        failures++; $display("FAIL bp_out[%0d] got=%f exp=%f", k, got_d[k], exp_v[k]);
      end
    end
    checks++;
    if (done_now !== 1'b1) begin
      failures++; $display("FAIL bp_done got=%b exp=1", done_now);
    end
  endtask

  task automatic test_zero_norm();
    stim_x[0] = 5.0; stim_x[1] = 7.0;
    run_row_a(2, 0.0, 0, 0);
    checks++;
    if (timed_out || n_got != 2 || got_d[0] != 5.0 || got_d[1] != 7.0) begin
      failures++; $display("FAIL zero_out n=%0d got=%f,%f exp=5.0,7.0", n_got, got_d[0], got_d[1]);
    end
    checks++;
    if (a_if.err_zero_norm !== 1'b1 || pe_norm_seen != 1.0) begin
      failures++; $display("FAIL zero_err got=%b norm=%f exp=1 norm=1.0", a_if.err_zero_norm, pe_norm_seen);
    end
    checks++;
    if (done_now !== 1'b1) begin
      failures++; $display("FAIL zero_done got=%b exp=1", done_now);
    end
  endtask

  task automatic test_zero_len();
    bit nr_seen = 0;
    a_if.start = 1'b1; a_if.row_len = 7'd0;
    step();
    a_if.start = 1'b0;
    #2;
    nr_seen |= a_if.norm_ready;
    checks++;
    if (a_if.done !== 1'b1 || a_if.err_zero_norm !== 1'b0) begin
      failures++; $display("FAIL zlen_done done=%b err=%b exp done=1 err=0", a_if.done, a_if.err_zero_norm);
    end
    step();
    #2;
    nr_seen |= a_if.norm_ready;
    checks++;
    if (a_if.done !== 1'b0 || a_if.busy !== 1'b0 || nr_seen) begin
      failures++; $display("FAIL zlen_end done=%b busy=%b norm_ready_seen=%b exp 0 0 0", a_if.done, a_if.busy, nr_seen);
    end
  endtask

  task automatic test_max_len_bubbles();
    int bad_last = 0;
    for (int i = 0; i < 64; i++) stim_x[i] = real'(i + 1);
    run_row_a(64, 2.0, 1, 0);
    checks++;
    if (timed_out || n_got != 64) begin
      failures++; $display("FAIL max_count got=%0d exp=64 timeout=%0d", n_got, timed_out);
    end
    for (int k = 0; k < n_got; k++) begin
      checks++;
      if (got_d[k] != real'(k + 1) / 2.0) begin
        failures++; $display("FAIL max_out[%0d] got=%f exp=%f", k, got_d[k], real'(k + 1) / 2.0);
      end
      if (got_l[k] !== (k == 63)) bad_last++;
    end
    checks++;
    if (bad_last != 0 || done_now !== 1'b1) begin
      failures++; $display("FAIL max_last bad_last=%0d done=%b exp 0 1", bad_last, done_now);
    end
  endtask

  task automatic test_reset_mid_row();
    bit done_seen = 0;
    a_if.start = 1'b1; a_if.row_len = 7'd5;
    step();
    a_if.start = 1'b0; a_if.norm_valid = 1'b1; a_if.norm_data = 1.0;
    step();
    a_if.norm_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_if.x_valid = 1'b1; a_if.x_data = real'(i + 1);
      step();
    end
    a_if.x_valid = 1'b0;
    reset = 1'b1;
    step();
    #2;
    checks++;
    if ({a_if.norm_ready, a_if.x_ready, a_if.pe_do_process, a_if.out_valid, a_if.out_last,
         a_if.busy, a_if.done, a_if.err_zero_norm} !== 8'b0 || a_if.pe_norm_in != 0.0) begin
      failures++; $display("FAIL midrst_outs got=%b norm=%f exp=00000000 norm=0.0",
        {a_if.norm_ready, a_if.x_ready, a_if.pe_do_process, a_if.out_valid, a_if.out_last,
         a_if.busy, a_if.done, a_if.err_zero_norm}, a_if.pe_norm_in);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      #2;
      done_seen |= a_if.done;
    end
    checks++;
    if (done_seen) begin
      failures++; $display("FAIL midrst_nodone got=1 exp=0");
    end
    stim_x[0] = 3.0; stim_x[1] = 9.0;
    run_row_a(2, 1.0, 0, 0);
    checks++;
    if (timed_out || n_got != 2 || got_d[0] != 3.0 || got_d[1] != 9.0 || done_now !== 1'b1) begin
      failures++; $display("FAIL midrst_fresh n=%0d got=%f,%f done=%b exp=3.0,9.0 done=1", n_got, got_d[0], got_d[1], done_now);
    end
  endtask

  task automatic test_depth3();
    real xs [2] = '{1.0, 3.0};
    real ev [2] = '{2.0, 6.0};
    real gd [2];
    int  ac [2], oc [2];
    int  na = 0, ng = 0;
    bit  last_seen = 0, gl1 = 0;
    b_if.start = 1'b1; b_if.row_len = 7'd2;
    step();
    b_if.start = 1'b0; b_if.norm_valid = 1'b1; b_if.norm_data = 0.5;
    step();
    b_if.norm_valid = 1'b0;
    for (int c = 0; c < 40 && !last_seen; c++) begin
      b_if.x_valid = (na < 2);
      b_if.x_data  = (na < 2) ? xs[na] : 0.0;
      b_if.out_ready = 1'b1;
      #2;
      if (b_if.x_valid && b_if.x_ready) begin ac[na] = cyc; na++; end
      if (b_if.out_valid && ng < 2) begin
        gd[ng] = b_if.out_data; oc[ng] = cyc;
        if (ng == 1) gl1 = b_if.out_last;
        ng++;
        last_seen = b_if.out_last;
      end
      step();
    end
    b_if.x_valid = 1'b0;
    #2;
    checks++;
    if (ng != 2 || !gl1 || b_if.done !== 1'b1) begin
      failures++; $display("FAIL d3_count n=%0d last=%b done=%b exp 2 1 1", ng, gl1, b_if.done);
    end
    for (int k = 0; k < ng; k++) begin
      checks++;
      if (gd[k] != ev[k] || oc[k] != ac[k] + 3) begin
        failures++; $display("FAIL d3_out[%0d] got=%f cyc=%0d exp=%f cyc=%0d", k, gd[k], oc[k], ev[k], ac[k] + 3);
      end
    end
    step();
  endtask

  initial begin
    a_if.start = 0; a_if.row_len = '0; a_if.norm_valid = 0; a_if.norm_data = 0.0;
    a_if.x_valid = 0; a_if.x_data = 0.0; a_if.out_ready = 1;
    b_if.start = 0; b_if.row_len = '0; b_if.norm_valid = 0; b_if.norm_data = 0.0;
    b_if.x_valid = 0; b_if.x_data = 0.0; b_if.out_ready = 1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_norm();
    test_zero_len();
    test_max_len_bubbles();
    test_reset_mid_row();
    test_depth3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
